// File: rtl/ram_port_b_arbiter_if.sv
// Bus bundle between the port-B arbiter, its two read-only requesters and the RAM.
// Master is the requester/RAM side; slave is the arbiter.
interface ram_port_b_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              audio_req;
  logic [ADDR_W-1:0] audio_addr;
  logic              audio_grant;
  logic              audio_valid;
  logic [DATA_W-1:0] audio_data;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_grant;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              busy;

  modport master (
    output audio_req, audio_addr, vga_req, vga_addr, ram_data,
    input  audio_grant, audio_valid, audio_data,
           vga_grant, vga_valid, vga_data, ram_addr, busy
  );

  modport slave (
    input  audio_req, audio_addr, vga_req, vga_addr, ram_data,
    output audio_grant, audio_valid, audio_data,
           vga_grant, vga_valid, vga_data, ram_addr, busy
  );
endinterface

// File: rtl/ram_port_b_arbiter.sv
// Shares RAM port B between the audio and VGA readers: one read in flight at a time,
// round-robin or fixed audio priority, with a one-cycle valid pulse per returned word.
module ram_port_b_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int READ_LATENCY   = 1,
  parameter int AUDIO_PRIORITY = 0
) (
  input logic                 clock,
  input logic                 reset,
  ram_port_b_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_AUDIO, OWN_VGA} owner_t;

  localparam logic [2:0] LATENCY = 3'(READ_LATENCY);

  state_t            r_state;
  state_t            w_nextState;
  owner_t            r_owner;
  owner_t            r_last;
  owner_t            w_winner;
  logic              w_anyReq;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [DATA_W-1:0] r_audioData;
  logic [DATA_W-1:0] r_vgaData;
  logic              r_audioValid;
  logic              r_vgaValid;
  logic              w_audioGrant;
  logic              w_vgaGrant;
  logic              w_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // VGA wins a tie only in round-robin mode and only when audio had the previous read.
  always_comb begin
    w_anyReq    = bus.audio_req | bus.vga_req;
    w_winner    = OWN_AUDIO;
    w_nextState = r_state;
    if (bus.vga_req && (!bus.audio_req || (AUDIO_PRIORITY == 0 && r_last == OWN_AUDIO)))
      w_winner = OWN_VGA;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = WAIT;
      WAIT:    if (r_cnt == 3'd0) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state == WAIT);
    w_audioGrant = w_busy && (r_owner == OWN_AUDIO);
    w_vgaGrant   = w_busy && (r_owner == OWN_VGA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= 3'd0;
      r_owner      <= OWN_AUDIO;
      r_last       <= OWN_VGA;
      r_ramAddr    <= '0;
      r_audioData  <= '0;
      r_vgaData    <= '0;
      r_audioValid <= 1'b0;
      r_vgaValid   <= 1'b0;
    end else begin
      r_audioValid <= 1'b0;
      r_vgaValid   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_ramAddr <= (w_winner == OWN_VGA) ? bus.vga_addr : bus.audio_addr;
            r_owner   <= w_winner;
            r_last    <= w_winner;
            r_cnt     <= LATENCY;
          end
        end
        WAIT: begin
          // The extra cycle at zero lets the RAM's registered output settle before capture.
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else if (r_owner == OWN_VGA) begin
            r_vgaData  <= bus.ram_data;
            r_vgaValid <= 1'b1;
          end else begin
            r_audioData  <= bus.ram_data;
            r_audioValid <= 1'b1;
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign bus.ram_addr    = r_ramAddr;
  assign bus.audio_grant = w_audioGrant;
  assign bus.audio_valid = r_audioValid;
  assign bus.audio_data  = r_audioData;
  assign bus.vga_grant   = w_vgaGrant;
  assign bus.vga_valid   = r_vgaValid;
  assign bus.vga_data    = r_vgaData;
  assign bus.busy        = w_busy;
endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Bench for ram_port_b_arbiter: three instances (round-robin L=1, audio priority L=1,
// round-robin L=4), each with its own port-B RAM model, checked through a scoreboard.
module tb_ram_port_b_arbiter;
  logic clock;
  logic reset;
  int   cyc = 0;
  int   testsRun = 0;
  int   failures = 0;

  typedef struct {
    int          inst;
    bit          isVga;
    logic [15:0] data;
    int          atCyc;
  } exp_t;

  exp_t expQ[$];

  ram_port_b_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  ram_port_b_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  ram_port_b_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  ram_port_b_arbiter #(.READ_LATENCY(1), .AUDIO_PRIORITY(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  ram_port_b_arbiter #(.READ_LATENCY(1), .AUDIO_PRIORITY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));
  ram_port_b_arbiter #(.READ_LATENCY(4), .AUDIO_PRIORITY(0)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM contents: byte-swapped address xor 0x5A5A, except one marker word.
  function automatic logic [15:0] memFunc(input logic [15:0] addr);
    if (addr == 16'h0123) return 16'hBEEF;
    return {addr[7:0], addr[15:8]} ^ 16'h5A5A;
  endfunction

  logic [15:0] ram0;
  logic [15:0] ram1;
  logic [15:0] pipe2 [4];

  always @(posedge clock) begin
    ram0     <= memFunc(bus0.ram_addr);
    ram1     <= memFunc(bus1.ram_addr);
    pipe2[0] <= memFunc(bus2.ram_addr);
    for (int i = 1; i < 4; i++) pipe2[i] <= pipe2[i-1];
  end

  assign bus0.ram_data = ram0;
  assign bus1.ram_data = ram1;
  assign bus2.ram_data = pipe2[3];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic aReq, input logic [15:0] aAddr,
                               input logic vReq, input logic [15:0] vAddr);
    case (inst)
      0: begin bus0.audio_req = aReq; bus0.audio_addr = aAddr; bus0.vga_req = vReq; bus0.vga_addr = vAddr; end
      1: begin bus1.audio_req = aReq; bus1.audio_addr = aAddr; bus1.vga_req = vReq; bus1.vga_addr = vAddr; end
      default: begin bus2.audio_req = aReq; bus2.audio_addr = aAddr; bus2.vga_req = vReq; bus2.vga_addr = vAddr; end
    endcase
  endtask

  task automatic expectRead(input int inst, input bit isVga, input logic [15:0] data, input int atCyc);
    exp_t e;
    e.inst  = inst;
    e.isVga = isVga;
    e.data  = data;
    e.atCyc = atCyc;
    expQ.push_back(e);
  endtask

  task automatic checkValid(input int inst, input bit isVga, input logic [15:0] data);
    exp_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL unexpected valid: inst %0d vga %0d data 0x%0h, expected no valid (cycle %0d)",
               inst, isVga, data, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("inst%0d valid source", inst), {inst[7:0], 7'd0, isVga},
                  {e.inst[7:0], 7'd0, e.isVga});
      checkOutput($sformatf("inst%0d read data", inst), {16'd0, data}, {16'd0, e.data});
      checkOutput($sformatf("inst%0d valid cycle", inst), cyc, e.atCyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus0.audio_valid) checkValid(0, 1'b0, bus0.audio_data);
    if (bus0.vga_valid)   checkValid(0, 1'b1, bus0.vga_data);
    if (bus1.audio_valid) checkValid(1, 1'b0, bus1.audio_data);
    if (bus1.vga_valid)   checkValid(1, 1'b1, bus1.vga_data);
    if (bus2.audio_valid) checkValid(2, 1'b0, bus2.audio_data);
    if (bus2.vga_valid)   checkValid(2, 1'b1, bus2.vga_data);
  end

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    int grantCount;
    int busyCount;

    reset = 1'b1;
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(1, 1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(2, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) @(negedge clock);

    checkOutput("reset ram_addr", {16'd0, bus0.ram_addr}, 32'h0);
    checkOutput("reset grants", {bus0.audio_grant, bus0.vga_grant}, 32'h0);
    checkOutput("reset valids", {bus0.audio_valid, bus0.vga_valid}, 32'h0);
    checkOutput("reset data", {bus0.audio_data, bus0.vga_data}, 32'h0);
    checkOutput("reset busy", {31'd0, bus0.busy}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single audio read at L=1.
    @(negedge clock);
    k = cyc;
    applyStimulus(0, 1'b1, 16'h0123, 1'b0, 16'h0);
    expectRead(0, 1'b0, 16'hBEEF, k + 3);
    grantCount = 0;
    busyCount  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin
        applyStimulus(0, 1'b0, 16'h0123, 1'b0, 16'h0);
        checkOutput("single ram_addr", {16'd0, bus0.ram_addr}, 32'h0123);
      end
      if (bus0.audio_grant) grantCount++;
      if (bus0.busy) busyCount++;
    end
    checkOutput("single grant cycles", grantCount, 2);
    checkOutput("single busy cycles", busyCount, 2);
    checkOutput("single audio_data", {16'd0, bus0.audio_data}, 32'hBEEF);
    checkOutput("single vga_data untouched", {16'd0, bus0.vga_data}, 32'h0);
    checkOutput("idle ram_addr held", {16'd0, bus0.ram_addr}, 32'h0123);

    // Round-robin tie right after reset: A, V, A, V.
    doReset();
    @(negedge clock);
    k = cyc;
    applyStimulus(0, 1'b1, 16'h0010, 1'b1, 16'h0020);
    expectRead(0, 1'b0, 16'h4A5A, k + 3);
    expectRead(0, 1'b1, 16'h7A5A, k + 6);
    expectRead(0, 1'b0, 16'h4A5A, k + 9);
    expectRead(0, 1'b1, 16'h7A5A, k + 12);
    for (int r = 0; r < 4; r++) begin
      @(negedge clock);
      checkOutput($sformatf("rr grant %0d", r), {bus0.audio_grant, bus0.vga_grant},
                  (r % 2 == 0) ? 32'h2 : 32'h1);
      repeat (2) @(negedge clock);
    end
    applyStimulus(0, 1'b0, 16'h0010, 1'b0, 16'h0020);
    repeat (3) @(negedge clock);

    // Fixed audio priority with both held: VGA starves until audio drops.
    @(negedge clock);
    k = cyc;
    applyStimulus(1, 1'b1, 16'h0030, 1'b1, 16'h0040);
    for (int j = 0; j < 6; j++) expectRead(1, 1'b0, 16'h6A5A, k + 3 + 3 * j);
    expectRead(1, 1'b1, 16'h1A5A, k + 21);
    grantCount = 0;
    repeat (18) begin
      @(negedge clock);
      if (bus1.vga_grant) grantCount++;
    end
    applyStimulus(1, 1'b0, 16'h0030, 1'b1, 16'h0040);
    checkOutput("prio vga starved", grantCount, 0);
    @(negedge clock);
    checkOutput("prio vga served next", {bus1.audio_grant, bus1.vga_grant}, 32'h1);
    applyStimulus(1, 1'b0, 16'h0030, 1'b0, 16'h0040);
    repeat (4) @(negedge clock);

    // READ_LATENCY=4, address change during WAIT must be ignored.
    @(negedge clock);
    k = cyc;
    applyStimulus(2, 1'b0, 16'h0, 1'b1, 16'h7FFF);
    expectRead(2, 1'b1, 16'hA525, k + 6);
    @(negedge clock);
    applyStimulus(2, 1'b0, 16'h0, 1'b0, 16'h1234);
    checkOutput("L4 ram_addr", {16'd0, bus2.ram_addr}, 32'h7FFF);
    repeat (3) @(negedge clock);
    checkOutput("L4 ram_addr held", {16'd0, bus2.ram_addr}, 32'h7FFF);
    checkOutput("L4 vga_grant", {31'd0, bus2.vga_grant}, 32'h1);
    repeat (4) @(negedge clock);
    checkOutput("L4 vga_data", {16'd0, bus2.vga_data}, 32'hA525);
    checkOutput("L4 busy after", {31'd0, bus2.busy}, 32'h0);

    // Reset in the second WAIT cycle discards the read.
    @(negedge clock);
    applyStimulus(0, 1'b1, 16'h0050, 1'b0, 16'h0);
    @(negedge clock);
    applyStimulus(0, 1'b0, 16'h0050, 1'b0, 16'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", {31'd0, bus0.busy}, 32'h0);
    checkOutput("async reset grants", {bus0.audio_grant, bus0.vga_grant}, 32'h0);
    checkOutput("async reset ram_addr", {16'd0, bus0.ram_addr}, 32'h0);
    checkOutput("async reset data", {bus0.audio_data, bus0.vga_data}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    @(negedge clock);
    k = cyc;
    applyStimulus(0, 1'b1, 16'h0050, 1'b0, 16'h0);
    expectRead(0, 1'b0, 16'h0A5A, k + 3);
    @(negedge clock);
    applyStimulus(0, 1'b0, 16'h0050, 1'b0, 16'h0);
    repeat (4) @(negedge clock);
    checkOutput("post-reset audio_data", {16'd0, bus0.audio_data}, 32'h0A5A);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end
endmodule

// File: doc/ram_port_b_arbiter.md
# ram_port_b_arbiter

Shares port B of the CPU's dual-port sound RAM between two read-only requesters: the audio `Ram_Reader` and the planned VGA reader. Sits between those readers and the RAM's `Address_B`/`data_b_out` pins in `TOP`. It arbitrates one read at a time, counts out the RAM's synchronous read latency, and returns the word to the winning requester with a one-cycle valid pulse. Round-robin by default, with optional fixed audio priority.

## Interface

- `ADDR_W`, 16, RAM port-B address width
- `DATA_W`, 16, RAM port-B data width
- `READ_LATENCY`, 1, RAM clock edges from address to valid data; legal range 1..4
- `AUDIO_PRIORITY`, 0, 1 = audio always wins a tie; 0 = round-robin

Ports:

- `clock`  in  1  single system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `audio_req`  in  1  audio read request, level-sensitive
- `audio_addr`  in  ADDR_W  audio read address
- `audio_grant`  out  1  audio owns port B (high while its read is in flight)
- `audio_valid`  out  1  one-cycle pulse: `audio_data` updated
- `audio_data`  out  DATA_W  last word read for audio
- `vga_req`  in  1  VGA read request, level-sensitive
- `vga_addr`  in  ADDR_W  VGA read address
- `vga_grant`  out  1  VGA owns port B
- `vga_valid`  out  1  one-cycle pulse: `vga_data` updated
- `vga_data`  out  DATA_W  last word read for VGA
- `ram_addr`  out  ADDR_W  registered, drives RAM `Address_B`
- `ram_data`  in  DATA_W  from RAM `data_b_out`
- `busy`  out  1  arbiter not in IDLE

## Operation

- FSM states are IDLE and WAIT. A `cnt` register (3 bits) and an `owner` register (audio/vga) support the FSM. A `last` register (audio/vga) drives round-robin.
- **IDLE, no request:** stay in IDLE. `ram_addr` holds its value.
- **IDLE, one request:** that requester wins.
- **IDLE, both requests:**
  - With `AUDIO_PRIORITY=1`, audio wins.
  - Otherwise the requester not equal to `last` wins.
- **On a win at edge E0:**
  - `ram_addr` loads the winner's address.
  - `owner` and `last` load the winner.
  - `cnt` loads `READ_LATENCY`.
  - The FSM moves to WAIT.
- **WAIT:** `cnt` decrements each edge while nonzero.
  - At the edge where `cnt==0`, `ram_data` is captured into the owner's data register.
  - The owner's valid goes high for the following cycle.
  - The FSM returns to IDLE.
- Address inputs are sampled only at the arbitration edge. Changes during WAIT are ignored.
- Request inputs are ignored in WAIT. A request that arrives during WAIT is served at the next IDLE edge.
- Requests are levels. A `req` still high at the IDLE edge is a new read. Holding `req` high streams back-to-back reads.
  - To get exactly one read, the requester drops `req` no later than its valid cycle.
- `*_grant` equals (state==WAIT && owner==x).
- `busy` equals (state==WAIT).
- The data registers of the non-owning requester never change.
- **Reset values:**
  - state=IDLE, `cnt`=0, `owner`=audio, `last`=vga (so audio wins the first tie).
  - `ram_addr`=0.
  - Both data outputs 0, both valids 0, both grants 0, `busy`=0.
- **Reset mid-WAIT:** the in-flight read is discarded and no valid pulse is emitted. After reset, arbitration restarts from IDLE.

## Timing

- Request seen at edge E0 → `ram_addr` valid from E0.
- Capture at edge E0+READ_LATENCY+1 → valid high in the cycle after it.
- Request-to-valid latency is READ_LATENCY+2 cycles. That is 3 cycles at the default.
- The IDLE arbitration edge is E0+READ_LATENCY+2.
- Sustained throughput is one read per READ_LATENCY+2 cycles, shared between requesters.
- With round-robin and both requesters streaming, grants alternate strictly: A, V, A, V…
- No requester waits more than one foreign read when `AUDIO_PRIORITY=0`.
- `audio_valid` and `vga_valid` are never high in the same cycle.

## Test plan

- **Single read, L=1:** RAM model returns `0xBEEF` for address `0x0123`; pulse `audio_req` with `audio_addr=0x0123` before E0.
  - `ram_addr=0x0123` after E0.
  - `audio_grant`/`busy` high for 2 cycles.
  - `audio_valid` high for exactly one cycle, 3 cycles after E0, with `audio_data=0xBEEF`.
  - `vga_data` stays 0.
- **Tie after reset, round-robin:** hold both requests, `audio_addr=0x0010`, `vga_addr=0x0020`.
  - Grant order is A, V, A, V.
  - Valids are spaced 3 cycles apart.
  - Each data output matches the model at its own address.
- **`AUDIO_PRIORITY=1`, both requests held for 20 cycles:** `vga_grant` never asserts. After `audio_req` drops, VGA is served on the next IDLE edge.
- **`READ_LATENCY=4`:** a single VGA read of `0x7FFF` returns its data with `vga_valid` 6 cycles after E0. Changing `vga_addr` during WAIT does not alter `ram_addr` or the returned word.
- **Reset mid-WAIT:** assert `reset` for one cycle in the second WAIT cycle.
  - All outputs return to 0 immediately (asynchronously).
  - No valid pulse appears.
  - A following audio request completes normally in 3 cycles.
